// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front-end for a word-only RAM, sub-word stores via read-modify-write.
// Optional MAU_ALIGN_CHECK_EN: misaligned half/word faults; otherwise low address bits are forced aligned.
module mem_access_unit #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic [31:0] ram_a_o,
  output logic [31:0] ram_wd_o,
  output logic        ram_we_o,
  input  logic [31:0] ram_rd_i
);
  typedef enum logic {IDLE, MERGE} state_t;
  state_t      state_q;
  logic [29:0] idx_q;
  logic [1:0]  off_q;
  logic        half_q;
  logic [15:0] data_q;
  logic        req_ready_q, resp_valid_q, resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic        in_merge, accept, misalign, fault;
  logic [1:0]  off;
  logic [31:0] lane, ld, mask, merged;
  assign in_merge = state_q == MERGE;
  assign accept   = req_valid_i & ~in_merge;
`ifdef MAU_ALIGN_CHECK_EN
  assign misalign = (req_size_i == 2'b01 & req_addr_i[0]) | (req_size_i == 2'b10 & |req_addr_i[1:0]);
  assign off      = req_addr_i[1:0];
`else
  assign misalign = 1'b0;
  assign off      = req_size_i == 2'b10 ? 2'b00 : req_size_i == 2'b01 ? {req_addr_i[1], 1'b0} : req_addr_i[1:0];
`endif
  assign fault  = &req_size_i | misalign | ({2'b00, req_addr_i[31:2]} >= 32'(RAM_WORDS));
  assign lane   = ram_rd_i >> {off, 3'b000};
  assign ld     = req_size_i == 2'b00 ? {{24{req_signed_i & lane[7]}}, lane[7:0]} :
                  req_size_i == 2'b01 ? {{16{req_signed_i & lane[15]}}, lane[15:0]} : lane;
  assign mask   = (half_q ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
  assign merged = (ram_rd_i & ~mask) | (({16'h0, data_q} << {off_q, 3'b000}) & mask);
  // RAM side is combinational; reset forces it quiet so an abandoned merge never writes
  assign ram_a_o  = rst ? 32'h0 : {in_merge ? idx_q : req_addr_i[31:2], 2'b00};
  assign ram_wd_o = rst ? 32'h0 : in_merge ? merged : req_wdata_i;
  assign ram_we_o = ~rst & (in_merge | (accept & req_we_i & req_size_i == 2'b10 & ~fault));
  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_fault_o = resp_fault_q;
  assign resp_rdata_o = resp_rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      idx_q        <= 30'h0;
      off_q        <= 2'b00;
      half_q       <= 1'b0;
      data_q       <= 16'h0;
    end else begin
      resp_valid_q <= 1'b0;
      if (in_merge) begin
        state_q      <= IDLE;
        req_ready_q  <= 1'b1;
        resp_valid_q <= 1'b1;
        resp_fault_q <= 1'b0;
      end else if (accept) begin
        if (fault) begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b1;
        end else if (!req_we_i) begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= ld;
        end else if (req_size_i == 2'b10) begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
        end else begin
          state_q     <= MERGE;
          req_ready_q <= 1'b0;
          idx_q       <= req_addr_i[31:2];
          off_q       <= off;
          half_q      <= req_size_i[0];
          data_q      <= req_wdata_i[15:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a simple word RAM model.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_fault, ram_we;
  logic [31:0] resp_rdata, ram_a, ram_wd, ram_rd;
  logic [31:0] mem [0:255];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.RAM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
    .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_fault_o(resp_fault), .ram_a_o(ram_a), .ram_wd_o(ram_wd), .ram_we_o(ram_we), .ram_rd_i(ram_rd)
  );
  assign ram_rd = mem[ram_a[9:2]];
  always @(posedge clk) if (ram_we) mem[ram_a[9:2]] <= ram_wd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
  endtask
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    cyc; cyc;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_fault", resp_fault, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_a", ram_a, 0);
    chk("rst_wd", ram_wd, 0);
    rst = 1'b0;
    req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    #1;
    chk("sw_we", ram_we, 1);
    chk("sw_a", ram_a, 32'h10);
    chk("sw_wd", ram_wd, 32'hDEADBEEF);
    chk("sw_ready", req_ready, 1);
    cyc;
    req(0, 2'b10, 0, 32'h10, 0);
    chk("sw_resp", resp_valid, 1);
    chk("sw_fault", resp_fault, 0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    #1 chk("lw_we", ram_we, 0);
    cyc;
    req_valid = 1'b0;
    chk("lw_resp", resp_valid, 1);
    chk("lw_data", resp_rdata, 32'hDEADBEEF);
    chk("lw_fault", resp_fault, 0);
    cyc;
    chk("idle_valid", resp_valid, 0);
    mem[4] = 32'h11223344;
    req(1, 2'b00, 0, 32'h12, 32'h000000AA);
    #1 chk("sb_acc_we", ram_we, 0);
    cyc;
    req_valid = 1'b0;
    chk("sb_ready", req_ready, 0);
    chk("sb_merge_we", ram_we, 1);
    chk("sb_merge_a", ram_a, 32'h10);
    chk("sb_merge_wd", ram_wd, 32'h11AA3344);
    chk("sb_early", resp_valid, 0);
    cyc;
    chk("sb_resp", resp_valid, 1);
    chk("sb_ready2", req_ready, 1);
    chk("sb_mem", mem[4], 32'h11AA3344);
    chk("sb_rdata", resp_rdata, 32'hDEADBEEF);
    mem[6] = 32'hAABBCCDD;
    req(1, 2'b01, 0, 32'h1A, 32'h55661234);
    cyc;
    req_valid = 1'b0;
    chk("sh_wd", ram_wd, 32'h1234CCDD);
    cyc;
    chk("sh_mem", mem[6], 32'h1234CCDD);
    mem[4] = 32'h8001FF7F;
    req(0, 2'b00, 0, 32'h10, 0);
    cyc;
    chk("lb0", resp_rdata, 32'h0000007F);
    req(0, 2'b00, 1, 32'h11, 0);
    cyc;
    chk("lb1_valid", resp_valid, 1);
    chk("lb1", resp_rdata, 32'hFFFFFFFF);
    req(0, 2'b01, 0, 32'h12, 0);
    cyc;
    chk("lhu", resp_rdata, 32'h00008001);
    req(0, 2'b01, 1, 32'h12, 0);
    cyc;
    chk("lh", resp_rdata, 32'hFFFF8001);
    req(0, 2'b01, 0, 32'h13, 0);
    cyc;
    req_valid = 1'b0;
    chk("lh13_valid", resp_valid, 1);
`ifdef MAU_ALIGN_CHECK_EN
    chk("lh13_fault", resp_fault, 1);
    chk("lh13_data", resp_rdata, 32'hFFFF8001);
`else
    chk("lh13_fault", resp_fault, 0);
    chk("lh13_data", resp_rdata, 32'h00008001);
`endif
    req(1, 2'b10, 0, 32'h400, 32'h12345678);
    #1 chk("oor_we", ram_we, 0);
    cyc;
    req(0, 2'b11, 0, 32'h10, 0);
    chk("oor_valid", resp_valid, 1);
    chk("oor_fault", resp_fault, 1);
    chk("oor_mem", mem[0], 32'h0);
    #1 chk("sz11_we", ram_we, 0);
    cyc;
    req_valid = 1'b0;
    chk("sz11_valid", resp_valid, 1);
    chk("sz11_fault", resp_fault, 1);
    cyc;
    mem[5] = 32'h55667788;
    req(1, 2'b00, 0, 32'h14, 32'h99);
    cyc;
    req_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rstm_we", ram_we, 0);
    cyc;
    rst = 1'b0;
    chk("rstm_mem", mem[5], 32'h55667788);
    chk("rstm_ready", req_ready, 1);
    chk("rstm_valid", resp_valid, 0);
    chk("rstm_fault", resp_fault, 0);
    chk("rstm_rdata", resp_rdata, 0);
    cyc;
    chk("rstm_idle", resp_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
